// File: rtl/a2d_share_arb_if.sv
// a2d_share_arb_if: requester-side and A2D-side signals of the shared converter arbiter
interface a2d_share_arb_if #(parameter int NUM_REQ = 4);
  logic [NUM_REQ-1:0] req;
  logic [3*NUM_REQ-1:0] req_chnnl;
  logic [NUM_REQ-1:0] gnt;
  logic strt_cnv;
  logic [2:0] chnnl;
  logic cnv_cmplt;
  logic [11:0] A2D_res;
  logic [11:0] res;
  logic [NUM_REQ-1:0] res_vld;
  logic busy;
  logic timeout_err;
  modport master (
    output req, req_chnnl, cnv_cmplt, A2D_res,
    input gnt, strt_cnv, chnnl, res, res_vld, busy, timeout_err
  );
  modport slave (
    input req, req_chnnl, cnv_cmplt, A2D_res,
    output gnt, strt_cnv, chnnl, res, res_vld, busy, timeout_err
  );
endinterface

// File: rtl/a2d_share_arb.sv
// a2d_share_arb: round-robin sharing of one A2D converter among NUM_REQ requesters with a watchdog
module a2d_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 1024
) (
  input logic clk,
  input logic rst,
  a2d_share_arb_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int WW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;
  state_t state, nxt;
  logic [IW-1:0] ptr, win, win_q;
  logic [WW-1:0] wd;
  logic wd_end;
  assign wd_end = wd == WW'(TIMEOUT - 1);
  assign bus.strt_cnv = state == START;
  assign bus.busy = state != IDLE;
  always_comb begin
    win = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (bus.req[(int'(ptr) + k) % NUM_REQ]) win = IW'((int'(ptr) + k) % NUM_REQ);
  end
  always_comb begin
    nxt = state == IDLE  ? (|bus.req ? START : IDLE) :
          state == START ? WAIT :
          state == WAIT  ? ((bus.cnv_cmplt || wd_end) ? DONE : WAIT) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      win_q <= '0;
      wd <= '0;
      bus.gnt <= '0;
      bus.chnnl <= '0;
      bus.res <= '0;
      bus.res_vld <= '0;
      bus.timeout_err <= 1'b0;
    end else begin
      state <= nxt;
      bus.res_vld <= '0;
      bus.timeout_err <= 1'b0;
      if (state == IDLE && |bus.req) begin
        bus.gnt <= NUM_REQ'(1) << win;
        bus.chnnl <= bus.req_chnnl[3*int'(win) +: 3];
        win_q <= win;
      end
      if (state == START) wd <= '0;
      if (state == WAIT) begin
        if (bus.cnv_cmplt) begin
          bus.res <= bus.A2D_res;
          bus.res_vld <= bus.gnt;
        end else if (wd_end) begin
          bus.timeout_err <= 1'b1;
        end else begin
          wd <= wd + 1'b1;
        end
      end
      if (state == DONE) begin
        bus.gnt <= '0;
        ptr <= IW'((int'(win_q) + 1) % NUM_REQ);
      end
    end
  end
endmodule
